dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage load/store requests.
- The datapath initiates with address, write data and byte enables; this block answers with read data after a programmable wait.
- It raises a stall toward the hazard unit while the access is outstanding.
- It holds an internal word-addressed SRAM array and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 10, word-index width; the array is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between accept and the array access; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  MEM-stage request present
- req_we  in  4  byte write enables; bit i writes bits [8i+7:8i]; 4'b0000 = read
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  block can accept a request this cycle
- mem_stall  out  1  hold F/D/E/M stages
- resp_valid  out  1  one-cycle pulse; response data valid
- resp_rdata  out  32  word read from the array after any write merge
- resp_err  out  1  access rejected: misaligned or out of range

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, counter=0, captured request registers=0, req_ready=1 (combinational from IDLE), mem_stall=0, resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1, capture addr, we and wdata.
  - If addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0, go to RESP with err_pending=1 and no array access.
  - Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter!=0, decrement it.
  - If counter==0, perform the access on word index addr[ADDR_WIDTH+1:2]. Each byte i with we[i]=1 takes wdata byte i; other bytes are kept.
  - Register the post-merge word into resp_rdata, then go to RESP.
- RESP:
  - resp_valid=1 for exactly this cycle, with req_ready=0.
  - resp_err=err_pending. On error, resp_rdata=0.
  - Next state is IDLE unconditionally.
- resp_valid and resp_err are 0 outside RESP. resp_rdata holds its last value.
- mem_stall = (IDLE && req_valid) || WAIT. It is deasserted in RESP, so the pipeline advances and captures resp_rdata in that cycle.
- Latency:
  - Valid access: request accepted at cycle t, resp_valid at t+LATENCY+1, mem_stall high for cycles t..t+LATENCY.
  - Error access: resp_valid at t+1, mem_stall high for cycle t only.
- Back-to-back requests: the next request can be accepted in the cycle after RESP, giving a minimum spacing of LATENCY+2 cycles.
- req_valid while in WAIT or RESP is ignored. The datapath is stalled during WAIT, so the request stays stable.
- Store of we=4'b1111: resp_rdata equals the written word (write-first).
- Reset mid-operation: rst in any state returns to IDLE next cycle and discards the captured request.
  - If rst coincides with the WAIT access cycle, the write is suppressed; reset wins.
  - resp_valid never pulses for an abandoned request.
- Counter is 8 bits wide.

Test Plan:
- LATENCY=2. Store addr=0x10, we=4'hF, wdata=0xDEADBEEF at t=0. Expect mem_stall high t..t+2, resp_valid at t+3, resp_rdata=0xDEADBEEF, resp_err=0. Then load 0x10 with we=0: expect rdata=0xDEADBEEF at the same relative latency.
- Byte merge. Store we=4'b0010, wdata=0x0000AA00 to 0x10 (holding 0xDEADBEEF). Expect resp_rdata=0xDEADAAEF. A following load returns 0xDEADAAEF.
- Misaligned. Load addr=0x12. Expect resp_valid at t+1 with resp_err=1 and rdata=0; mem_stall high for cycle t only; array unchanged, so a subsequent load of 0x10 still returns the prior value.
- Out of range, ADDR_WIDTH=10. Store addr=0x1000, wdata=0x12345678. Expect resp_err=1 and no write. A load of 0x0 returns its previously written value, not 0x12345678.
- Back-to-back. Hold req_valid=1 with two loads, LATENCY=1. First resp_valid at t+2. Second request accepted at t+3, its resp_valid at t+5. req_ready=0 during WAIT/RESP. No extra resp_valid pulses.
- Reset mid-WAIT, LATENCY=3. Store 0x55555555 to 0x20 (holding 0x11111111), assert rst at t+2. Expect no resp_valid; state IDLE; req_ready=1 and mem_stall=0 the cycle after reset; a later load of 0x20 returns 0x11111111.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the pipeline's MEM stage. It accepts one
// load/store request at a time and waits a programmable number of cycles
// before accessing an internal word-addressed SRAM. It returns the word as
// it stands after any byte-merge, then pulses resp_valid for one cycle.
// While the access is outstanding, mem_stall holds the upstream stages.
// If the address is misaligned or beyond the array, the request is answered
// one cycle later with resp_err set and the array is not touched.

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [7:0]            counter;
  logic [ADDR_WIDTH-1:0] capIndex;
  logic [3:0]            capWe;
  logic [31:0]           capWdata;
  logic                  errPending;

  logic [31:0]           memArray [DEPTH];

  logic                  reqBad;
  logic                  doAccess;
  logic [31:0]           storedWord;
  logic [31:0]           mergedWord;

  // An incoming address is rejected if it is not word aligned or if it has bits set above the array's index range.
  always_comb begin
    reqBad = (req_addr[1:0] != 2'b00) ||
             ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // The array access happens on the last WAIT cycle. Bytes whose enable is set are taken from the store data; all other bytes keep their stored value.
  always_comb begin
    doAccess   = (state == WAIT) && (counter == 8'd0);
    storedWord = memArray[capIndex];
    mergedWord = storedWord;
    for (int i = 0; i < 4; i++) begin
      if (capWe[i]) begin
        mergedWord[8*i +: 8] = capWdata[8*i +: 8];
      end
    end
  end

  // Control FSM: capture in IDLE, count down in WAIT, present the response in RESP. Reset discards any request still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= 8'd0;
      capIndex   <= '0;
      capWe      <= 4'd0;
      capWdata   <= 32'd0;
      errPending <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            capIndex <= req_addr[ADDR_WIDTH+1:2];
            capWe    <= req_we;
            capWdata <= req_wdata;
            if (reqBad) begin
              errPending <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else begin
              errPending <= 1'b0;
              counter    <= COUNT_LOAD;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (counter != 8'd0) begin
            counter <= counter - 8'd1;
          end else begin
            resp_rdata <= mergedWord;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The array is never cleared. A write that lands in the same cycle as reset is dropped so that the abandoned store has no effect.
  always_ff @(posedge clk) begin
    if (!rst && doAccess) begin
      memArray[capIndex] <= mergedWord;
    end
  end

  // The handshake and stall outputs are decoded directly from the state. The stall drops in RESP so the pipeline captures resp_rdata that cycle.
  always_comb begin
    req_ready  = (state == IDLE);
    mem_stall  = ((state == IDLE) && req_valid) || (state == WAIT);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && errPending;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Scoreboard bench for dmem_responder. Three instances share the request bus
// but each has its own req_valid line. Their LATENCY values are 2, 1 and 3.
// The stimulus pushes the expected responses, each tagged with its instance
// and the cycle it is due in. A separate monitor pops an entry and compares
// it whenever any instance pulses resp_valid.

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqWe;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        memStall  [3];
  logic        respValid [3];
  logic [31:0] respRdata [3];
  logic        respErr   [3];

  int cycleNum   = 0;
  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } ExpEntry;

  ExpEntry expQ[$];
  ExpEntry monEntry;

  // Free-running clock with a cycle index used to time-stamp responses.
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid[g]),
      .req_we     (reqWe),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .req_ready  (reqReady[g]),
      .mem_stall  (memStall[g]),
      .resp_valid (respValid[g]),
      .resp_rdata (respRdata[g]),
      .resp_err   (respErr[g])
    );
  end

  function automatic int latOf(input int inst);
    return (inst == 0) ? 2 : ((inst == 1) ? 1 : 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, actual, expected, cycleNum);
  endtask

  // Monitor: every response pulse must match the oldest expected entry in instance, cycle, data and error flag.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (respValid[i] === 1'b1) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected resp_valid: inst=%0d actual=1 expected=0 (cycle %0d)", i, cycleNum);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("resp inst", 32'(i), 32'(monEntry.inst));
          checkOutput("resp cycle", 32'(cycleNum), 32'(monEntry.cycle));
          checkOutput("resp rdata", respRdata[i], monEntry.rdata);
          checkOutput("resp err", 32'(respErr[i]), 32'(monEntry.err));
        end
      end
    end
  end

  // Issue one request and follow the handshake until the block is back in IDLE. The task is entered just after a rising edge.
  task automatic applyStimulus(input int inst, input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr);
    int lat = expErr ? 0 : latOf(inst);
    int t   = cycleNum;
    reqAddr        = addr;
    reqWe          = we;
    reqWdata       = wdata;
    reqValid[inst] = 1'b1;
    expQ.push_back('{inst, expRdata, expErr, t + lat + 1});
    @(negedge clk);
    checkOutput("stall at accept", 32'(memStall[inst]), 32'd1);
    checkOutput("ready at accept", 32'(reqReady[inst]), 32'd1);
    @(posedge clk);
    #1;
    reqValid[inst] = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      checkOutput("stall in wait", 32'(memStall[inst]), 32'd1);
      checkOutput("ready in wait", 32'(reqReady[inst]), 32'd0);
    end
    @(negedge clk);
    checkOutput("stall in resp", 32'(memStall[inst]), 32'd0);
    checkOutput("ready in resp", 32'(reqReady[inst]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Hang guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [5:0] expReady;
    logic [5:0] expStall;
    int t;

    rst      = 1'b1;
    reqWe    = 4'd0;
    reqAddr  = 32'd0;
    reqWdata = 32'd0;
    for (int i = 0; i < 3; i++) reqValid[i] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset ready", 32'(reqReady[i]), 32'd1);
      checkOutput("reset stall", 32'(memStall[i]), 32'd0);
      checkOutput("reset valid", 32'(respValid[i]), 32'd0);
      checkOutput("reset rdata", respRdata[i], 32'd0);
      checkOutput("reset err", 32'(respErr[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-word store, then load back (LATENCY=2).
    applyStimulus(0, 32'h10, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);

    // Single-byte merge.
    applyStimulus(0, 32'h10, 4'b0010, 32'h0000AA00, 32'hDEADAAEF, 1'b0);
    applyStimulus(0, 32'h10, 4'h0,    32'h0,        32'hDEADAAEF, 1'b0);

    // Two-byte merge on another word.
    applyStimulus(0, 32'h0, 4'hF,    32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    applyStimulus(0, 32'h0, 4'b0101, 32'h00330044, 32'hA533A544, 1'b0);

    // Misaligned load, then confirm the array is unchanged.
    applyStimulus(0, 32'h12, 4'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus(0, 32'h10, 4'h0, 32'h0, 32'hDEADAAEF, 1'b0);

    // Out-of-range store would alias word 0 if it were not rejected.
    applyStimulus(0, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1'b1);
    applyStimulus(0, 32'h0,    4'h0, 32'h0, 32'hA533A544, 1'b0);

    // Back-to-back loads with req_valid held (LATENCY=1).
    applyStimulus(1, 32'h40, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    t = cycleNum;
    expReady = 6'b001001;
    expStall = 6'b011011;
    reqAddr  = 32'h40;
    reqWe    = 4'h0;
    reqWdata = 32'h0;
    reqValid[1] = 1'b1;
    expQ.push_back('{1, 32'hCAFEF00D, 1'b0, t + 2});
    expQ.push_back('{1, 32'hCAFEF00D, 1'b0, t + 5});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("b2b ready", 32'(reqReady[1]), 32'(expReady[k]));
      checkOutput("b2b stall", 32'(memStall[1]), 32'(expStall[k]));
      @(posedge clk);
      #1;
      if (k == 4) reqValid[1] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("b2b idle ready", 32'(reqReady[1]), 32'd1);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of WAIT (LATENCY=3).
    applyStimulus(2, 32'h20, 4'hF, 32'h11111111, 32'h11111111, 1'b0);
    reqAddr  = 32'h20;
    reqWe    = 4'hF;
    reqWdata = 32'h55555555;
    reqValid[2] = 1'b1;
    @(posedge clk); #1; reqValid[2] = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset ready", 32'(reqReady[2]), 32'd1);
    checkOutput("post-reset stall", 32'(memStall[2]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(2, 32'h20, 4'h0, 32'h0, 32'h11111111, 1'b0);

    // Reset landing on the access cycle itself must suppress the write.
    reqAddr  = 32'h20;
    reqWe    = 4'hF;
    reqWdata = 32'h77777777;
    reqValid[2] = 1'b1;
    @(posedge clk); #1; reqValid[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset2 ready", 32'(reqReady[2]), 32'd1);
    checkOutput("post-reset2 stall", 32'(memStall[2]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(2, 32'h20, 4'h0, 32'h0, 32'h11111111, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
